// File: rtl/alu8_exec_pkg.sv
// Shared definitions for the alu8 execute stage: opcodes, slice operation codes,
// FSM state encoding and the decoded control bundle.
package alu8_exec_pkg;

    localparam logic [2:0] OPC_AND  = 3'b000;
    localparam logic [2:0] OPC_OR   = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;
    localparam logic [2:0] OPC_NOR  = 3'b100;
    localparam logic [2:0] OPC_NAND = 3'b101;
    localparam logic [2:0] OPC_SLT  = 3'b110;
    localparam logic [2:0] OPC_SLTU = 3'b111;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_SET  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic       cin;
        logic [1:0] operation;
        logic       two_pass;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu8.sv
// 8-bit ripple ALU built from 1-bit slices with operand inversion, carry-in and a
// LESS operation that passes the bit-0 less input through (upper bits read 0).
module alu8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       a_inv_i,
    input  logic       b_inv_i,
    input  logic       cin_i,
    input  logic [1:0] operation_i,
    input  logic       less_i,
    output logic [7:0] result_o,
    output logic       cout_o,
    output logic       c6_o
);
    import alu8_exec_pkg::*;

    logic [8:0] carry;

    always_comb begin
        logic ai;
        logic bi;
        carry    = '0;
        result_o = '0;
        carry[0] = cin_i;
        for (int i = 0; i < 8; i++) begin
            ai = a_i[i] ^ a_inv_i;
            bi = b_i[i] ^ b_inv_i;
            carry[i+1] = (ai & bi) | (carry[i] & (ai ^ bi));
            case (operation_i)
                OP_AND:  result_o[i] = ai & bi;
                OP_OR:   result_o[i] = ai | bi;
                OP_ADD:  result_o[i] = ai ^ bi ^ carry[i];
                default: result_o[i] = (i == 0) ? less_i : 1'b0;
            endcase
        end
    end

    // Carry out of slice 7 and slice 6; their XOR is the signed overflow.
    assign cout_o = carry[8];
    assign c6_o   = carry[7];

endmodule

// File: rtl/alu8_exec_ctrl_dec.sv
// Opcode to slice-control decoder. Opcode 111 (SLTU) is decoded only when
// ALU8_EXEC_SLTU_EN is defined; otherwise it is flagged illegal.
module alu8_ctrl_dec
    import alu8_exec_pkg::*;
(
    input  logic [2:0] op_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (op_i)
            OPC_AND:  ctrl_o.operation = OP_AND;
            OPC_OR:   ctrl_o.operation = OP_OR;
            OPC_ADD:  ctrl_o.operation = OP_ADD;
            OPC_SUB: begin
                ctrl_o.operation = OP_ADD;
                ctrl_o.b_inv     = 1'b1;
                ctrl_o.cin       = 1'b1;
            end
            // De Morgan: NOR/NAND reuse AND/OR with both operands inverted.
            OPC_NOR: begin
                ctrl_o.operation = OP_AND;
                ctrl_o.a_inv     = 1'b1;
                ctrl_o.b_inv     = 1'b1;
            end
            OPC_NAND: begin
                ctrl_o.operation = OP_OR;
                ctrl_o.a_inv     = 1'b1;
                ctrl_o.b_inv     = 1'b1;
            end
            OPC_SLT: begin
                ctrl_o.operation = OP_ADD;
                ctrl_o.b_inv     = 1'b1;
                ctrl_o.cin       = 1'b1;
                ctrl_o.two_pass  = 1'b1;
            end
            default: begin
`ifdef ALU8_EXEC_SLTU_EN
                ctrl_o.operation = OP_ADD;
                ctrl_o.b_inv     = 1'b1;
                ctrl_o.cin       = 1'b1;
                ctrl_o.two_pass  = 1'b1;
`else
                ctrl_o.illegal   = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu8_exec_stage.sv
// Registered execute stage around one alu8 instance; SLT/SLTU take a second LESS pass.
// Optional SLTU (opcode 111) is enabled by defining ALU8_EXEC_SLTU_EN.
module alu8_exec_stage
    import alu8_exec_pkg::*;
#(
    parameter bit CLEAR_ON_IDLE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [7:0] in_src1,
    input  logic [7:0] in_src2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_zero,
    output logic       out_carry,
    output logic       out_ovf,
    output logic       out_neg,
    output logic       out_illegal
);

    state_t     state_q;
    ctrl_t      dec;

    logic [7:0] a_q, b_q;
    logic       a_inv_q, b_inv_q, cin_q, two_pass_q, sltu_q, set_q;
    logic [1:0] oper_q;

    logic [7:0] result_q;
    logic       zero_q, carry_q, ovf_q, neg_q, illegal_q, out_valid_q;

    logic       alu_a_inv, alu_b_inv, alu_cin, alu_less;
    logic [1:0] alu_oper;
    logic [7:0] alu_res;
    logic       alu_cout, alu_c6;
    logic       alu_ovf;
    logic       set_d;

    alu8_ctrl_dec u_dec (
        .op_i   (in_op),
        .ctrl_o (dec)
    );

    // The SET pass overrides the latched controls with a bare LESS operation.
    always_comb begin
        alu_a_inv = a_inv_q;
        alu_b_inv = b_inv_q;
        alu_cin   = cin_q;
        alu_oper  = oper_q;
        alu_less  = 1'b0;
        if (state_q == S_SET) begin
            alu_a_inv = 1'b0;
            alu_b_inv = 1'b0;
            alu_cin   = 1'b0;
            alu_oper  = OP_LESS;
            alu_less  = set_q;
        end
    end

    alu8 u_alu (
        .a_i         (a_q),
        .b_i         (b_q),
        .a_inv_i     (alu_a_inv),
        .b_inv_i     (alu_b_inv),
        .cin_i       (alu_cin),
        .operation_i (alu_oper),
        .less_i      (alu_less),
        .result_o    (alu_res),
        .cout_o      (alu_cout),
        .c6_o        (alu_c6)
    );

    assign alu_ovf = alu_cout ^ alu_c6;
    // Signed less-than corrects the sign by overflow; unsigned uses the borrow.
    assign set_d   = sltu_q ? ~alu_cout : (alu_res[7] ^ alu_ovf);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_src1;
                        b_q        <= in_src2;
                        a_inv_q    <= dec.a_inv;
                        b_inv_q    <= dec.b_inv;
                        cin_q      <= dec.cin;
                        oper_q     <= dec.operation;
                        two_pass_q <= dec.two_pass;
                        sltu_q     <= (in_op == OPC_SLTU);
                        if (dec.illegal) begin
                            result_q    <= '0;
                            zero_q      <= 1'b0;
                            carry_q     <= 1'b0;
                            ovf_q       <= 1'b0;
                            neg_q       <= 1'b0;
                            illegal_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (two_pass_q) begin
                        set_q   <= set_d;
                        state_q <= S_SET;
                    end else begin
                        result_q    <= alu_res;
                        zero_q      <= (alu_res == 8'h00);
                        neg_q       <= alu_res[7];
                        carry_q     <= (oper_q == OP_ADD) & alu_cout;
                        ovf_q       <= (oper_q == OP_ADD) & alu_ovf;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_SET: begin
                    result_q    <= alu_res;
                    zero_q      <= (alu_res == 8'h00);
                    neg_q       <= alu_res[7];
                    carry_q     <= 1'b0;
                    ovf_q       <= 1'b0;
                    illegal_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        if (CLEAR_ON_IDLE) begin
                            result_q  <= '0;
                            zero_q    <= 1'b0;
                            carry_q   <= 1'b0;
                            ovf_q     <= 1'b0;
                            neg_q     <= 1'b0;
                            illegal_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Gated by rst_n so the stage never advertises readiness while held in reset.
    assign in_ready    = (state_q == S_IDLE) & rst_n;
    assign out_valid   = out_valid_q;
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_carry   = carry_q;
    assign out_ovf     = ovf_q;
    assign out_neg     = neg_q;
    assign out_illegal = illegal_q;

endmodule

// File: doc/alu8_exec_stage.md
Name: alu8_exec_stage

Overview:
Registered execute stage that takes opcode-level requests over a valid/ready handshake and decodes them into the slice-level controls (A_invert, B_invert, cin, operation, less). It drives one internal instance of the existing 8-bit ripple ALU (alu8), then registers the result and flags for a downstream consumer. SLT/SLTU take a second ALU pass, with the sign or borrow fed back into the bit-0 less input. One operation is in flight at a time.

Parameters:
CLEAR_ON_IDLE, 0, 1 = out_result and all flags are cleared to 0 on the DONE->IDLE transition; 0 = they hold their last value.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  request valid
in_ready  output  1  stage can accept; high only in IDLE
in_op  input  3  opcode
in_src1  input  8  operand A
in_src2  input  8  operand B
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts the result
out_result  output  8  registered result
out_zero  output  1  out_result == 0
out_carry  output  1  ALU carry out (ADD/SUB only, else 0)
out_ovf  output  1  signed overflow = carry[7]^carry[6] (ADD/SUB only, else 0)
out_neg  output  1  out_result[7]
out_illegal  output  1  unsupported opcode was accepted

Behaviour:
- Opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 NAND, 110 SLT, 111 SLTU (only with the optional feature; otherwise illegal).
- Slice operation encoding: 00 AND, 01 OR, 10 ADD, 11 LESS.
- Decode:
  - NOR = AND with A_inv=B_inv=1.
  - NAND = OR with A_inv=B_inv=1.
  - SUB = ADD with B_inv=1, cin=1.
  - less=0 except in the SLT/SLTU second pass.
- FSM states: IDLE, EXEC, SET, DONE.
  - IDLE: in_ready=1. in_valid at an edge latches op and operands, then goes to EXEC.
  - EXEC: the ALU evaluates the latched operands.
    - Non-SLT ops: result and flags are captured at the next edge, then DONE.
    - SLT/SLTU: this pass runs SUB. set = res[7]^ovf for SLT, or ~cout for SLTU, is captured; then SET.
  - SET: the ALU runs operation=11, less=set, all other controls 0. The result is captured, then DONE.
  - DONE: out_valid=1; result and flags are stable. out_ready at an edge goes to IDLE.
- Latency and throughput:
  - Accept at edge N: out_valid is high after edge N+1 (simple ops) or N+2 (SLT/SLTU).
  - No accept is possible in the same cycle as out_ready, so minimum initiation interval is 3 cycles.
- Illegal opcode: skips EXEC. Goes IDLE->DONE at the next edge with out_result=0x00, out_illegal=1, all other flags 0 (out_zero=0).
- SLT/SLTU flags: out_carry=0, out_ovf=0; zero/neg follow the 0x00/0x01 result.
- Reset: rst_n low at any edge forces IDLE, out_valid=0, and out_result and all flags to 0. It aborts any in-flight op, including mid-SLT. in_ready=0 while rst_n is low and 1 in the first cycle after release.
- in_valid while not in IDLE is ignored; the request is not latched.
- Operands are taken only at accept; later changes on in_src* have no effect.

Optional Feature:
ALU8_EXEC_SLTU_EN
- Defined: opcode 111 = unsigned set-less-than, result 0x01 iff in_src1 < in_src2 unsigned, via borrow (~cout) in the SUB pass. Same 2-pass timing as SLT.
- Undefined: opcode 111 takes the illegal path.

Decomposition:
- Package alu8_exec_pkg:
  - opcode localparams;
  - slice operation codes (OP_AND/OR/ADD/LESS);
  - FSM state encoding (2-bit);
  - control-bundle typedef {a_inv, b_inv, cin, operation[1:0], two_pass, illegal}.
- Sub-module alu8_ctrl_dec: combinational opcode -> control bundle.
- Datapath: one alu8 instance, driven by the latched operands and the FSM-muxed controls.

Test Plan:
- ADD 0x7F+0x01 -> 0x80, ovf=1, neg=1, carry=0, zero=0; out_valid after edge N+1.
- SUB 0x05-0x05 -> 0x00, zero=1, carry=1, ovf=0.
- SLT 0x80,0x01 -> 0x01 at N+2; SLT 0x01,0x80 -> 0x00 with zero=1; carry=ovf=0 in both.
- NOR 0xF0,0x0F -> 0x00, zero=1; NAND 0xFF,0x0F -> 0xF0, neg=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid.
  - Result stays stable and in_ready=0; a pulsed in_valid with new data is not latched.
  - out_ready=1 gives IDLE next edge, out_valid=0, and out_result cleared iff CLEAR_ON_IDLE=1.
- Opcode 111 without macro -> 0x00, illegal=1 after N+1; with macro, SLTU 0x01,0xFF -> 0x01.
- Reset mid-SLT (rst_n=0 in SET) -> IDLE next edge, out_valid=0, outputs 0.
